// File: rtl/regfile_dump_if.sv
// Beat stream carrying a dumped register value and its index.
// Valid/ready handshake toward the debug/trace path.
interface regfile_dump_if #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32
) ();
  logic                     valid;
  logic                     ready;
  logic [DATA_WIDTH-1:0]    data;
  logic [ADDRESS_WIDTH-1:0] index;
  logic                     last;

  modport master (
    output valid,
    output data,
    output index,
    output last,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    input  index,
    input  last,
    output ready
  );
endinterface

// File: rtl/regfile_dump.sv
// Register file read-out engine: walks every register through a
// spare async read port and streams index/value beats.
module regfile_dump #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [ADDRESS_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0]    rd_data,
  regfile_dump_if.master           dump
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t state;
  state_t state_nx;

  logic [ADDRESS_WIDTH:0] ptr;
  logic                   exhausted;
  logic                   load;
  logic                   hs;
  logic                   fin;

  assign exhausted = ptr[ADDRESS_WIDTH];
  assign rd_addr   = ptr[ADDRESS_WIDTH-1:0];
  assign busy      = (state == RUN);
  assign hs        = dump.valid && dump.ready;
  assign load      = busy && !exhausted
                   && (!dump.valid || dump.ready);
  assign fin       = busy && hs && dump.last;

  // Next state: leave IDLE on start, return after the last beat.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = RUN;
      RUN:  if (fin)   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Pointer, output beat registers and the done pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr        <= '0;
      done       <= 1'b0;
      dump.valid <= 1'b0;
      dump.data  <= '0;
      dump.index <= '0;
      dump.last  <= 1'b0;
    end else begin
      done <= fin;
      if (state == IDLE && start) ptr <= '0;
      if (load) begin
        dump.data  <= rd_data;
        dump.index <= ptr[ADDRESS_WIDTH-1:0];
        dump.last  <= (ptr[ADDRESS_WIDTH-1:0]
                       == {ADDRESS_WIDTH{1'b1}});
        dump.valid <= 1'b1;
        ptr        <= ptr + 1'b1;
      end else if (hs) begin
        dump.valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_dump.sv
// Scoreboard bench for regfile_dump: randomized register contents
// and back-pressure against a queue-based reference of each dump.
module tb_regfile_dump;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy;
  logic          done;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] rf [NR];

  always #5 clk = ~clk;

  assign rd_data = rf[rd_addr];

  regfile_dump_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  regfile_dump #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .dump    (bus)
  );

  typedef struct {
    logic [AW-1:0] idx;
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t exp_q[$];
  beat_t hold;
  bit    hold_v = 0;
  bit    pend = 0;
  int    total = 0;
  int    passed = 0;
  int    cyc = 0;
  int    start_n = 0;
  int    stalls = 0;
  int    ndone = 0;
  int    mode = 0;
  int    ovr_idx = -1;
  logic [DW-1:0] ovr_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: compares each handshake against the expected queue,
  // checks held beats and the done pulse timing.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (done || pend) begin
        chk("done_pulse", {63'd0, done}, {63'd0, pend});
        if (pend) begin
          chk("done_cycle", cyc, start_n + NR + 1 + stalls);
          chk("busy_at_done", {63'd0, busy}, 64'd0);
        end
        if (done) ndone++;
        pend = 0;
      end
      if (hold_v)
        chk("hold_beat",
            {bus.valid, bus.last, bus.index, bus.data},
            {1'b1, hold.last, hold.idx, hold.data});
      hold_v = 0;
      if (bus.valid && !bus.ready) begin
        stalls++;
        hold_v = 1;
        hold = '{idx: bus.index, data: bus.data, last: bus.last};
      end
      if (bus.valid && bus.ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 64'd1, 64'd0);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("beat_index", bus.index, e.idx);
          chk("beat_data", bus.data, e.data);
          chk("beat_last", {63'd0, bus.last}, {63'd0, e.last});
          if (bus.last) pend = 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    case (mode)
      1:       bus.ready = ~bus.ready;
      2:       bus.ready = 1'($urandom_range(1));
      default: bus.ready = 1'b1;
    endcase
  endtask

  task automatic do_start();
    for (int i = 0; i < NR; i++) begin
      beat_t b;
      b.idx  = AW'(i);
      b.data = (i == ovr_idx) ? ovr_data : rf[i];
      b.last = (i == NR - 1);
      exp_q.push_back(b);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    start_n = cyc;
    stalls = 0;
    if (mode == 1) bus.ready = 1'b0;
    chk("busy_after_start", {63'd0, busy}, 64'd1);
    chk("rd_addr_after_start", rd_addr, 64'd0);
  endtask

  task automatic wait_done(output int dc);
    dc = -1;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (done) begin
        dc = cyc;
        break;
      end
    end
    if (dc < 0) chk("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_beat(input int idx);
    bit seen;
    seen = 0;
    for (int i = 0; i < 500; i++) begin
      if (bus.valid && bus.index == AW'(idx)) begin
        seen = 1;
        break;
      end
      tick();
    end
    if (!seen) chk("beat_timeout", 64'd0, 64'd1);
  endtask

  task automatic post_done();
    chk("valid_in_done_cycle", {63'd0, bus.valid}, 64'd0);
    tick();
    chk("done_one_cycle", {63'd0, done}, 64'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
    chk({tag, "_done"}, {63'd0, done}, 64'd0);
    chk({tag, "_outs"},
        {bus.valid, bus.last, bus.index, bus.data, rd_addr}, 64'd0);
  endtask

  initial begin
    int dc;
    int nd0;
    bus.ready = 1'b1;
    for (int i = 0; i < NR; i++) rf[i] = 32'h1000_0000 + i;
    tick();
    tick();
    chk_zero("reset");
    rst_n = 1'b1;
    tick();

    // Full dump with ready held high.
    do_start();
    chk("first_cycle_valid", {63'd0, bus.valid}, 64'd0);
    wait_done(dc);
    chk("latency_ready1", dc - start_n, 33);
    post_done();

    // Alternating ready.
    mode = 1;
    do_start();
    wait_done(dc);
    chk("latency_toggle", dc - start_n, 64);
    mode = 0;
    post_done();

    // Second start mid-dump is ignored.
    nd0 = ndone;
    do_start();
    wait_beat(10);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(dc);
    chk("latency_restart_ignored", dc - start_n, 33);
    post_done();
    repeat (5) tick();
    chk("single_done", ndone - nd0, 1);

    // Reset mid-dump during beat 17.
    do_start();
    wait_beat(17);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    pend = 0;
    hold_v = 0;
    chk_zero("abort");
    nd0 = ndone;
    repeat (40) tick();
    chk("no_done_after_abort", ndone - nd0, 0);
    do_start();
    wait_done(dc);
    chk("latency_after_abort", dc - start_n, 33);
    post_done();

    // Write r5 on the falling edge before its capture edge.
    ovr_idx = 5;
    ovr_data = 32'hDEAD_BEEF;
    do_start();
    while (cyc < start_n + 5) tick();
    @(negedge clk);
    rf[5] = 32'hDEAD_BEEF;
    wait_done(dc);
    ovr_idx = -1;
    post_done();

    // Start in the done cycle.
    do_start();
    wait_done(dc);
    do_start();
    wait_done(dc);
    chk("latency_back_to_back", dc - start_n, 33);
    post_done();

    // Random contents and random back-pressure.
    mode = 2;
    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < NR; i++) rf[i] = $urandom;
      do_start();
      wait_done(dc);
      repeat ($urandom_range(3)) tick();
    end
    mode = 0;
    repeat (3) tick();

    chk("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
